// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the multi-cycle sequencer: instruction codes, status codes, FSM states.
// Pure declarations; no timing or flow-control behaviour of its own.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    typedef logic [2:0] stat_t;

    localparam stat_t STAT_AOK = 3'd1;
    localparam stat_t STAT_HLT = 3'd2;
    localparam stat_t STAT_ADR = 3'd3;
    localparam stat_t STAT_INS = 3'd4;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEMORY    = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_PCUPD     = 3'd6;
    localparam logic [2:0] S_HALTED    = 3'd7;

    // cmov is included unconditionally; the Regs block applies Cnd itself.
    function automatic logic writesReg(input logic [3:0] ic);
        return ic inside {ICODE_RRMOVQ, ICODE_IRMOVQ, ICODE_MRMOVQ, ICODE_OPQ,
                          ICODE_CALL, ICODE_RET, ICODE_PUSHQ, ICODE_POPQ};
    endfunction

endpackage

// File: rtl/y86_multicycle_seq_if.sv
// Sequencer <-> datapath/memory bundle: decode info and ready/req handshakes in, strobes and status out.
// No storage; master is the sequencer side, slave the datapath/memory side.
interface y86_multicycle_seq_if #(parameter int CNT_W = 32);

    logic             run;
    logic [3:0]       icode;
    logic             instr_valid;
    logic             imem_ready;
    logic             imem_error;
    logic             mem_rd;
    logic             mem_wr;
    logic             dmem_ready;
    logic             dmem_error;
    logic             imem_req;
    logic             dmem_req;
    logic             cc_we;
    logic             reg_we;
    logic             pc_we;
    logic [2:0]       state;
    logic [2:0]       stat;
    logic             busy;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  run, icode, instr_valid, imem_ready, imem_error,
               mem_rd, mem_wr, dmem_ready, dmem_error,
        output imem_req, dmem_req, cc_we, reg_we, pc_we,
               state, stat, busy, cycle_cnt, instr_cnt
    );

    modport slave (
        output run, icode, instr_valid, imem_ready, imem_error,
               mem_rd, mem_wr, dmem_ready, dmem_error,
        input  imem_req, dmem_req, cc_we, reg_we, pc_we,
               state, stat, busy, cycle_cnt, instr_cnt
    );

endinterface

// File: rtl/y86_sat_counter.sv
// Saturating up-counter: count advances one per cycle with inc high and sticks at all-ones.
// Registered, one-cycle update latency; no backpressure.
module y86_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/y86_multicycle_seq.sv
// Y86-64 multi-cycle stage sequencer: F/D/E/M/WB/PC FSM, status/halt owner, perf counters; 5-6 cycles/instr at zero wait.
// Waits indefinitely (or up to MEM_TIMEOUT) on imem/dmem ready; strobes are registered and fire in their stage's cycle.
module y86_multicycle_seq
    import y86_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    y86_multicycle_seq_if.master bus
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 2);

    logic [2:0]      stateQ;
    logic [2:0]      stateNext;
    stat_t           statQ;
    stat_t           statNext;
    logic [3:0]      icodeQ;
    logic [TO_W-1:0] toCnt;
    logic            waiting;
    logic            expired;
    logic            ccWeQ;
    logic            regWeQ;
    logic            pcWeQ;
    logic            busyNow;
    logic [CNT_W-1:0] cycleCnt;
    logic [CNT_W-1:0] instrCnt;

    assign waiting = ((stateQ == S_FETCH)  && !bus.imem_ready) ||
                     ((stateQ == S_MEMORY) && !bus.dmem_ready);
    // toCnt has counted the earlier wait cycles, so this is the MEM_TIMEOUT-th one.
    assign expired = (MEM_TIMEOUT != 0) && waiting && (toCnt == TO_W'(MEM_TIMEOUT - 1));

    always_comb begin
        stateNext = stateQ;
        statNext  = statQ;
        case (stateQ)
            S_IDLE: begin
                if (bus.run) stateNext = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ready) begin
                    if (bus.imem_error) begin
                        statNext  = STAT_ADR;
                        stateNext = S_HALTED;
                    end else if (!bus.instr_valid) begin
                        statNext  = STAT_INS;
                        stateNext = S_HALTED;
                    end else if (bus.icode == ICODE_HALT) begin
                        statNext  = STAT_HLT;
                        stateNext = S_HALTED;
                    end else begin
                        stateNext = S_DECODE;
                    end
                end else if (expired) begin
                    statNext  = STAT_ADR;
                    stateNext = S_HALTED;
                end
            end
            S_DECODE:  stateNext = S_EXECUTE;
            S_EXECUTE: stateNext = (bus.mem_rd || bus.mem_wr) ? S_MEMORY : S_WRITEBACK;
            S_MEMORY: begin
                if (bus.dmem_ready) begin
                    if (bus.dmem_error) begin
                        statNext  = STAT_ADR;
                        stateNext = S_HALTED;
                    end else begin
                        stateNext = S_WRITEBACK;
                    end
                end else if (expired) begin
                    statNext  = STAT_ADR;
                    stateNext = S_HALTED;
                end
            end
            S_WRITEBACK: stateNext = S_PCUPD;
            S_PCUPD:     stateNext = bus.run ? S_FETCH : S_IDLE;
            default:     stateNext = stateQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= S_IDLE;
            statQ  <= STAT_AOK;
            icodeQ <= '0;
            toCnt  <= '0;
            ccWeQ  <= 1'b0;
            regWeQ <= 1'b0;
            pcWeQ  <= 1'b0;
        end else begin
            stateQ <= stateNext;
            statQ  <= statNext;
            if ((stateQ == S_FETCH) && bus.imem_ready) icodeQ <= bus.icode;
            if (stateNext != stateQ) begin
                toCnt <= '0;
            end else if (waiting) begin
                toCnt <= toCnt + TO_W'(1);
            end
            // Registered off the next state so each strobe is high exactly during its stage.
            ccWeQ  <= (stateNext == S_EXECUTE)   && (icodeQ == ICODE_OPQ);
            regWeQ <= (stateNext == S_WRITEBACK) && writesReg(icodeQ);
            pcWeQ  <= (stateNext == S_PCUPD);
        end
    end

    assign busyNow = (stateQ != S_IDLE) && (stateQ != S_HALTED);

    y86_sat_counter #(.W(CNT_W)) u_cycleCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (busyNow),
        .count (cycleCnt)
    );

    y86_sat_counter #(.W(CNT_W)) u_instrCnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stateQ == S_PCUPD),
        .count (instrCnt)
    );

    assign bus.imem_req  = (stateQ == S_FETCH);
    assign bus.dmem_req  = (stateQ == S_MEMORY);
    assign bus.cc_we     = ccWeQ;
    assign bus.reg_we    = regWeQ;
    assign bus.pc_we     = pcWeQ;
    assign bus.state     = stateQ;
    assign bus.stat      = statQ;
    assign bus.busy      = busyNow;
    assign bus.cycle_cnt = cycleCnt;
    assign bus.instr_cnt = instrCnt;

endmodule
